// File: rtl/quadrature_count_driver.sv
// Front end for the 4-bit universal up/down counter: turns a bouncing
// quadrature encoder and a load button into one-cycle S1/S0 commands plus the
// parallel-load value. Illegal encoder transitions raise a sticky Error.
module quadrature_count_driver #(
  parameter int LENGTH          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              CLOCK,
  input  logic              Reset,
  input  logic              QA,
  input  logic              QB,
  input  logic              LoadRequest,
  input  logic [LENGTH-1:0] LoadValue,
  input  logic              ErrorClear,
  output logic              S1,
  output logic              S0,
  output logic [LENGTH-1:0] P_out,
  output logic              Direction,
  output logic              Error
);

  localparam int            CntW    = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] CmdHold = 2'b00;
  localparam logic [1:0] CmdUp   = 2'b01;
  localparam logic [1:0] CmdDown = 2'b10;
  localparam logic [1:0] CmdLoad = 2'b11;

  // State encoding equals the filtered {A,B} pair.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quadState_t;

  // Bit 2 = load button, bit 1 = phase A, bit 0 = phase B.
  logic [2:0]      rawIn;
  logic [2:0]      syncMeta_p0;
  logic [2:0]      sync_p1;
  logic [2:0]      filt_p2;
  logic [CntW-1:0] debCnt [3];

  quadState_t quadState;
  quadState_t quadNext;
  quadState_t filtState;
  logic       initDone;
  logic       initNext;
  logic       stepUp;
  logic       stepDown;
  logic       stepIllegal;
  logic       stepAny;

  logic       loadPrev;
  logic       loadRise;
  logic       pending;
  logic       pendingUp;
  logic [1:0] cmdNext;
  logic       pendingNext;
  logic       pendingUpNext;
  logic       dirNext;
  logic       errNext;

  assign rawIn     = {LoadRequest, QA, QB};
  assign filtState = quadState_t'(filt_p2[1:0]);
  assign loadRise  = filt_p2[2] & ~loadPrev;
  assign stepAny   = stepUp | stepDown;

  // Two-flop synchronizers for the asynchronous encoder and button inputs.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      syncMeta_p0 <= '0;
      sync_p1     <= '0;
    end else begin
      syncMeta_p0 <= rawIn;
      sync_p1     <= syncMeta_p0;
    end
  end

  // Debounce: a filtered bit follows its synced bit only after it has
  // differed for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      filt_p2 <= '0;
      for (int i = 0; i < 3; i++) debCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != filt_p2[i]) begin
          if (debCnt[i] == CntLast) begin
            filt_p2[i] <= sync_p1[i];
            debCnt[i]  <= '0;
          end else begin
            debCnt[i] <= debCnt[i] + CntW'(1);
          end
        end else begin
          debCnt[i] <= '0;
        end
      end
    end
  end

  // Quadrature state register, plus the flag recording the first adoption.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      quadState <= Q00;
      initDone  <= 1'b0;
    end else begin
      quadState <= quadNext;
      initDone  <= initNext;
    end
  end

  // Next state: follow the filtered pair and classify the transition.
  always_comb begin
    quadNext    = quadState;
    initNext    = initDone;
    stepUp      = 1'b0;
    stepDown    = 1'b0;
    stepIllegal = 1'b0;
    if (filtState != quadState) begin
      quadNext = filtState;
      if (!initDone) begin
        initNext = 1'b1;
      end else begin
        case (quadState)
          Q00: begin
            stepUp   = (filtState == Q01);
            stepDown = (filtState == Q10);
          end
          Q01: begin
            stepUp   = (filtState == Q11);
            stepDown = (filtState == Q00);
          end
          Q11: begin
            stepUp   = (filtState == Q10);
            stepDown = (filtState == Q01);
          end
          default: begin
            stepUp   = (filtState == Q00);
            stepDown = (filtState == Q11);
          end
        endcase
        stepIllegal = ~(stepUp | stepDown);
      end
    end
  end

  // Command selection: a load wins the edge and defers a coincident step by
  // one cycle; a deferred step goes out before any newer step.
  always_comb begin
    cmdNext       = CmdHold;
    pendingNext   = pending;
    pendingUpNext = pendingUp;
    dirNext       = Direction;
    if (loadRise) begin
      cmdNext = CmdLoad;
      if (stepAny) begin
        pendingNext   = 1'b1;
        pendingUpNext = stepUp;
      end
    end else if (pending) begin
      cmdNext       = pendingUp ? CmdUp : CmdDown;
      dirNext       = pendingUp;
      pendingNext   = stepAny;
      pendingUpNext = stepUp;
    end else if (stepAny) begin
      cmdNext = stepUp ? CmdUp : CmdDown;
      dirNext = stepUp;
    end
    if (stepIllegal) begin
      errNext = 1'b1;
    end else if (ErrorClear) begin
      errNext = 1'b0;
    end else begin
      errNext = Error;
    end
  end

  // Registered command outputs, load value capture and sticky error.
  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      S1        <= 1'b0;
      S0        <= 1'b0;
      P_out     <= '0;
      Direction <= 1'b0;
      Error     <= 1'b0;
      pending   <= 1'b0;
      pendingUp <= 1'b0;
      loadPrev  <= 1'b0;
    end else begin
      {S1, S0}  <= cmdNext;
      if (loadRise) P_out <= LoadValue;
      Direction <= dirNext;
      Error     <= errNext;
      pending   <= pendingNext;
      pendingUp <= pendingUpNext;
      loadPrev  <= filt_p2[2];
    end
  end

endmodule

// File: tb/tb_quadrature_count_driver.sv
// Randomized and directed bench for quadrature_count_driver, checked every
// cycle against a behavioural model built from a command FIFO.
module tb_quadrature_count_driver;

  localparam int LENGTH = 4;
  localparam int D      = 4;

  logic              CLOCK = 1'b0;
  logic              Reset;
  logic              QA;
  logic              QB;
  logic              LoadRequest;
  logic [LENGTH-1:0] LoadValue;
  logic              ErrorClear;
  logic              S1;
  logic              S0;
  logic [LENGTH-1:0] P_out;
  logic              Direction;
  logic              Error;

  quadrature_count_driver #(.LENGTH(LENGTH), .DEBOUNCE_CYCLES(D)) dut (
    .CLOCK(CLOCK),
    .Reset(Reset),
    .QA(QA),
    .QB(QB),
    .LoadRequest(LoadRequest),
    .LoadValue(LoadValue),
    .ErrorClear(ErrorClear),
    .S1(S1),
    .S0(S0),
    .P_out(P_out),
    .Direction(Direction),
    .Error(Error)
  );

  always #5 CLOCK = ~CLOCK;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [2:0]        mS1, mS2, mFilt;   // bit2 load, bit1 A, bit0 B
  int                mRun [3];
  logic [1:0]        mState;
  logic              mInit, mLoadPrev;
  logic [1:0]        mQueue [$];
  logic [1:0]        mCmd;
  logic [LENGTH-1:0] mP;
  logic              mDir, mErr;

  int cyc = 0;
  int pulseUp, pulseDown, pulseLoad, lastCmdCycle;
  logic [1:0] cmdHist [$];
  logic [1:0] upSeq [4];

  function automatic int pos(logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic modelReset();
    mS1 = '0; mS2 = '0; mFilt = '0;
    for (int i = 0; i < 3; i++) mRun[i] = 0;
    mState = 2'b00; mInit = 1'b0; mLoadPrev = 1'b0;
    mQueue.delete();
    mCmd = 2'b00; mP = '0; mDir = 1'b0; mErr = 1'b0;
  endtask

  // One rising edge of the reference behaviour, using inputs at that edge.
  task automatic modelEdge();
    int   delta;
    logic illegal;
    logic [1:0] step;
    logic [1:0] c;
    illegal = 1'b0;
    step    = 2'b00;
    if (mFilt[1:0] != mState) begin
      if (!mInit) begin
        mInit = 1'b1;
      end else begin
        delta = (pos(mFilt[1:0]) - pos(mState) + 4) % 4;
        if (delta == 1)      step = 2'b01;
        else if (delta == 3) step = 2'b10;
        else                 illegal = 1'b1;
      end
      mState = mFilt[1:0];
    end
    if (mFilt[2] && !mLoadPrev) begin
      mQueue.push_back(2'b11);
      mP = LoadValue;
    end
    mLoadPrev = mFilt[2];
    if (step != 2'b00) mQueue.push_back(step);
    if (mQueue.size() > 0) begin
      c = mQueue.pop_front();
      mCmd = c;
      if (c == 2'b01) mDir = 1'b1;
      else if (c == 2'b10) mDir = 1'b0;
    end else begin
      mCmd = 2'b00;
    end
    if (illegal) mErr = 1'b1;
    else if (ErrorClear) mErr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mS2[i] != mFilt[i]) begin
        mRun[i]++;
        if (mRun[i] == D) begin
          mFilt[i] = mS2[i];
          mRun[i]  = 0;
        end
      end else begin
        mRun[i] = 0;
      end
    end
    mS2 = mS1;
    mS1 = {LoadRequest, QA, QB};
  endtask

  task automatic checkEq(string name, int actual, int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock, update the model, compare every output.
  task automatic tick();
    @(posedge CLOCK);
    if (Reset) modelReset();
    else modelEdge();
    #1;
    cyc++;
    tests++;
    if ({S1, S0} !== mCmd || P_out !== mP || Direction !== mDir || Error !== mErr) begin
      fails++;
      $display("FAIL cycle %0d: got cmd=%b P=%h dir=%b err=%b, expected cmd=%b P=%h dir=%b err=%b",
               cyc, {S1, S0}, P_out, Direction, Error, mCmd, mP, mDir, mErr);
    end
    if ({S1, S0} == 2'b01) pulseUp++;
    if ({S1, S0} == 2'b10) pulseDown++;
    if ({S1, S0} == 2'b11) pulseLoad++;
    if (S1 | S0) lastCmdCycle = cyc;
    cmdHist.push_back({S1, S0});
  endtask

  task automatic hold(logic qa, logic qb, int n);
    QA = qa;
    QB = qb;
    repeat (n) tick();
  endtask

  task automatic clearCounts();
    pulseUp = 0; pulseDown = 0; pulseLoad = 0; lastCmdCycle = -1;
    cmdHist.delete();
  endtask

  int   c0, lat, first, r, n;
  logic [1:0] cur, nxt;

  initial begin
    upSeq[0] = 2'b00; upSeq[1] = 2'b01; upSeq[2] = 2'b11; upSeq[3] = 2'b10;
    Reset = 1'b0; QA = 1'b0; QB = 1'b0; LoadRequest = 1'b0;
    LoadValue = '0; ErrorClear = 1'b0;
    modelReset();
    #2 Reset = 1'b1;
    #1;
    checkEq("reset_cmd", int'({S1, S0}), 0);
    checkEq("reset_pout", int'(P_out), 0);
    checkEq("reset_dir_err", int'({Direction, Error}), 0);
    repeat (2) tick();
    Reset = 1'b0;

    // Up sequence: first change only initialises
    hold(0, 0, 10);
    clearCounts();
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    checkEq("up_pulses", pulseUp, 3);
    checkEq("up_no_down", pulseDown, 0);
    checkEq("up_direction", int'(Direction), 1);
    checkEq("up_error", int'(Error), 0);

    // Down sequence
    clearCounts();
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
    checkEq("down_pulses", pulseDown, 4);
    checkEq("down_no_up", pulseUp, 0);
    checkEq("down_direction", int'(Direction), 0);

    // Glitch shorter than the debounce window
    clearCounts();
    hold(1, 0, 3); hold(0, 0, 10);
    checkEq("glitch_no_cmd", pulseUp + pulseDown + pulseLoad, 0);

    // Stable change: latency from input change to command
    clearCounts();
    c0 = cyc;
    QA = 1'b1;
    for (int k = 0; k < 20 && lastCmdCycle < 0; k++) tick();
    lat = (lastCmdCycle < 0) ? -1 : lastCmdCycle - c0;
    checkEq("step_latency", lat, 7);
    checkEq("step_is_down", pulseDown, 1);
    hold(1, 0, 5);
    hold(0, 0, 10);

    // Load press and release
    clearCounts();
    LoadValue = 4'h7;
    LoadRequest = 1'b1;
    hold(0, 0, 20);
    checkEq("load_pulses", pulseLoad, 1);
    checkEq("load_pout", int'(P_out), 7);
    clearCounts();
    LoadRequest = 1'b0;
    hold(0, 0, 20);
    checkEq("release_no_cmd", pulseUp + pulseDown + pulseLoad, 0);

    // Load and step landing on the same edge
    clearCounts();
    LoadValue = 4'hA;
    LoadRequest = 1'b1;
    hold(0, 1, 15);
    first = -1;
    for (int i = 0; i < cmdHist.size(); i++)
      if (first < 0 && cmdHist[i] != 2'b00) first = i;
    if (first >= 0 && first + 1 < cmdHist.size()) begin
      checkEq("sim_first_load", int'(cmdHist[first]), 3);
      checkEq("sim_then_up", int'(cmdHist[first + 1]), 1);
    end else begin
      checkEq("sim_cmd_seen", first, 0);
    end
    checkEq("sim_pout", int'(P_out), 10);
    LoadRequest = 1'b0;
    hold(0, 0, 12);

    // Illegal transition, error clear, reset during a command
    clearCounts();
    hold(1, 1, 12);
    checkEq("illegal_error", int'(Error), 1);
    checkEq("illegal_no_cmd", pulseUp + pulseDown + pulseLoad, 0);
    ErrorClear = 1'b1;
    tick();
    ErrorClear = 1'b0;
    checkEq("error_cleared", int'(Error), 0);
    clearCounts();
    QA = 1'b1; QB = 1'b0;
    for (int k = 0; k < 20 && lastCmdCycle < 0; k++) tick();
    checkEq("pre_reset_cmd", int'({S1, S0}), 1);
    #2 Reset = 1'b1;
    #1;
    modelReset();
    checkEq("async_reset_cmd", int'({S1, S0}), 0);
    checkEq("async_reset_pout", int'(P_out), 0);
    checkEq("async_reset_dir_err", int'({Direction, Error}), 0);
    repeat (2) tick();
    Reset = 1'b0;
    hold(1, 0, 12);

    // Randomized walk: steps, illegal jumps, glitches, loads, clears
    for (int seg = 0; seg < 250; seg++) begin
      cur = {QA, QB};
      r = $urandom_range(0, 9);
      if (r < 4)       nxt = upSeq[(pos(cur) + 1) % 4];
      else if (r < 8)  nxt = upSeq[(pos(cur) + 3) % 4];
      else if (r == 8) nxt = ~cur;
      else             nxt = cur;
      if ($urandom_range(0, 4) == 0) LoadRequest = ~LoadRequest;
      LoadValue = LENGTH'($urandom);
      QA = nxt[1];
      QB = nxt[0];
      if (seg == 120) begin
        Reset = 1'b1;
        modelReset();
        repeat (2) tick();
        Reset = 1'b0;
      end
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        ErrorClear = ($urandom_range(0, 15) == 0);
        tick();
      end
      ErrorClear = 1'b0;
    end
    hold(QA, QB, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
